// File: rtl/cdb_complete_arbiter_pkg.sv
// cdb_complete_arbiter_pkg: shared CDB defaults and packet/mask types
package cdb_complete_arbiter_pkg;
    localparam int CDB_N = 2;
    localparam int NUM_FU_TOTAL = 8;
    localparam int PREG_W_DEF = 6;
    localparam int ROB_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int BMASK_W_DEF = 4;
    typedef logic [BMASK_W_DEF-1:0] bmask_t;
    typedef struct packed {
        logic [PREG_W_DEF-1:0] preg;
        logic [ROB_W_DEF-1:0] rob_idx;
        logic [DATA_W_DEF-1:0] result;
        logic valid;
    } cdb_packet_t;
endpackage

// File: rtl/cdb_complete_arbiter_fu_result_buffer.sv
// fu_result_buffer: per-FU result FIFO with credit ready, branch squash and mask clear
module fu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int PAY_W = 43,
    parameter int BMASK_W = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push_valid,
    input  logic [PAY_W-1:0] push_data,
    input  logic [BMASK_W-1:0] push_bmask,
    output logic ready,
    input  logic br_valid,
    input  logic br_mispredict,
    input  logic [BMASK_W-1:0] br_tag,
    input  logic pop,
    output logic head_valid,
    output logic [PAY_W-1:0] head_data
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    logic [PAY_W-1:0] data_q [DEPTH];
    logic [BMASK_W-1:0] bmask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic squash, resolve, push_ok, do_pop;
    assign squash = br_valid && br_mispredict;
    assign resolve = br_valid && !br_mispredict;
    assign ready = count < CNT_W'(DEPTH);
    assign push_ok = push_valid && ready && !(squash && |(push_bmask & br_tag));
    assign head_valid = count != '0 && valid_q[rd_ptr] && !(squash && |(bmask_q[rd_ptr] & br_tag));
    assign head_data = data_q[rd_ptr];
    // a dead head (squashed or squashing now) drains without a grant
    assign do_pop = count != '0 && (pop || !head_valid);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                data_q[j] <= '0;
                bmask_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (resolve) bmask_q[j] <= bmask_q[j] & ~br_tag;
                if (squash && |(bmask_q[j] & br_tag)) valid_q[j] <= 1'b0;
            end
            if (push_ok) begin
                data_q[wr_ptr] <= push_data;
                bmask_q[wr_ptr] <= resolve ? push_bmask & ~br_tag : push_bmask;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(do_pop);
        end
    end
    assert property (@(posedge clock) disable iff (reset) !(push_valid && !ready));
endmodule

// File: rtl/cdb_complete_arbiter.sv
// cdb_complete_arbiter: per-FU result buffers feeding an N-lane rotating-priority CDB
module cdb_complete_arbiter
    import cdb_complete_arbiter_pkg::*;
#(
    parameter int N = CDB_N,
    parameter int NUM_FU = NUM_FU_TOTAL,
    parameter int BUF_DEPTH = 2,
    parameter int PREG_W = PREG_W_DEF,
    parameter int ROB_W = ROB_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BMASK_W = BMASK_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic [NUM_FU-1:0] fu_valid,
    input  logic [NUM_FU*PREG_W-1:0] fu_preg,
    input  logic [NUM_FU*ROB_W-1:0] fu_rob_idx,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    input  logic [NUM_FU*BMASK_W-1:0] fu_bmask,
    output logic [NUM_FU-1:0] fu_ready,
    input  logic br_valid,
    input  logic br_mispredict,
    input  logic [BMASK_W-1:0] br_tag,
    output logic [N-1:0] cdb_valid,
    output logic [N*PREG_W-1:0] cdb_preg,
    output logic [N*ROB_W-1:0] cdb_rob_idx,
    output logic [N*DATA_W-1:0] cdb_result,
    output logic [N*NUM_FU-1:0] cdb_gnt
);
    localparam int PAY_W = PREG_W + ROB_W + DATA_W;
    localparam int FU_W = $clog2(NUM_FU);
    logic [NUM_FU-1:0] head_valid, pop, taken, rgnt;
    logic [PAY_W-1:0] head_data [NUM_FU];
    logic [NUM_FU-1:0] lane_gnt [N];
    logic [PAY_W-1:0] lane_pay [N];
    logic [2*NUM_FU-1:0] dbl, ugnt;
    logic [FU_W-1:0] rr_ptr, next_ptr;
    logic [FU_W:0] adv, sum;
    for (genvar i = 0; i < NUM_FU; i++) begin : g_buf
        fu_result_buffer #(.DEPTH(BUF_DEPTH), .PAY_W(PAY_W), .BMASK_W(BMASK_W)) u_buf (
            .clock(clock),
            .reset(reset),
            .push_valid(fu_valid[i]),
            .push_data({fu_preg[i*PREG_W +: PREG_W], fu_rob_idx[i*ROB_W +: ROB_W], fu_result[i*DATA_W +: DATA_W]}),
            .push_bmask(fu_bmask[i*BMASK_W +: BMASK_W]),
            .ready(fu_ready[i]),
            .br_valid(br_valid),
            .br_mispredict(br_mispredict),
            .br_tag(br_tag),
            .pop(pop[i]),
            .head_valid(head_valid[i]),
            .head_data(head_data[i])
        );
    end
    // scan in rotated order (bit o = FU rr_ptr+o), then rotate grants back
    always_comb begin
        dbl = {head_valid, head_valid} >> rr_ptr;
        taken = '0;
        adv = '0;
        rgnt = '0;
        ugnt = '0;
        pop = '0;
        for (int k = 0; k < N; k++) begin
            rgnt = '0;
            for (int o = 0; o < NUM_FU; o++)
                if (dbl[o] && !taken[o] && rgnt == '0) begin
                    rgnt[o] = 1'b1;
                    adv = (FU_W+1)'(o + 1);
                end
            taken = taken | rgnt;
            ugnt = {rgnt, rgnt} << rr_ptr;
            lane_gnt[k] = ugnt[2*NUM_FU-1:NUM_FU];
            pop = pop | lane_gnt[k];
            lane_pay[k] = '0;
            for (int i = 0; i < NUM_FU; i++)
                lane_pay[k] = lane_pay[k] | (lane_gnt[k][i] ? head_data[i] : '0);
        end
        sum = {1'b0, rr_ptr} + adv;
        next_ptr = sum >= (FU_W+1)'(NUM_FU) ? FU_W'(sum - (FU_W+1)'(NUM_FU)) : FU_W'(sum);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            cdb_valid <= '0;
            cdb_preg <= '0;
            cdb_rob_idx <= '0;
            cdb_result <= '0;
            cdb_gnt <= '0;
        end else begin
            if (|pop) rr_ptr <= next_ptr;
            for (int k = 0; k < N; k++) begin
                cdb_valid[k] <= |lane_gnt[k];
                cdb_gnt[k*NUM_FU +: NUM_FU] <= lane_gnt[k];
                {cdb_preg[k*PREG_W +: PREG_W], cdb_rob_idx[k*ROB_W +: ROB_W], cdb_result[k*DATA_W +: DATA_W]} <= lane_pay[k];
            end
        end
    end
endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// tb_cdb_complete_arbiter: directed checks of buffering, rotation, squash, resolve and reset
module tb_cdb_complete_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] fu_valid = '0;
    logic [47:0] fu_preg = '0;
    logic [39:0] fu_rob_idx = '0;
    logic [255:0] fu_result = '0;
    logic [31:0] fu_bmask = '0;
    logic [7:0] fu_ready;
    logic br_valid = 1'b0;
    logic br_mispredict = 1'b0;
    logic [3:0] br_tag = '0;
    logic [1:0] cdb_valid;
    logic [11:0] cdb_preg;
    logic [9:0] cdb_rob_idx;
    logic [63:0] cdb_result;
    logic [15:0] cdb_gnt;
    int tests = 0;
    int fails = 0;
    cdb_complete_arbiter dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_preg(fu_preg), .fu_rob_idx(fu_rob_idx),
        .fu_result(fu_result), .fu_bmask(fu_bmask), .fu_ready(fu_ready),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .br_tag(br_tag),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_rob_idx(cdb_rob_idx),
        .cdb_result(cdb_result), .cdb_gnt(cdb_gnt)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic push(input int i, input logic [5:0] p, input logic [4:0] r, input logic [31:0] d, input logic [3:0] b);
        fu_valid[i] = 1'b1;
        fu_preg[i*6 +: 6] = p;
        fu_rob_idx[i*5 +: 5] = r;
        fu_result[i*32 +: 32] = d;
        fu_bmask[i*4 +: 4] = b;
    endtask
    task automatic idle();
        fu_valid = '0;
        br_valid = 1'b0;
        br_mispredict = 1'b0;
        br_tag = '0;
    endtask
    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    initial begin
        #2;
        check("rst_valid", cdb_valid, 0);
        check("rst_gnt", cdb_gnt, 0);
        check("rst_result", cdb_result, 0);
        tick();
        reset = 1'b0;
        check("rst_ready", fu_ready, 8'hFF);
        // single FU 3 result, two-cycle latency
        push(3, 6'd5, 5'd1, 32'hDEAD, 4'b0000);
        tick();
        idle();
        check("t1_ready", fu_ready, 8'hFF);
        check("t1_early", cdb_valid, 0);
        tick();
        check("t1_valid", cdb_valid, 2'b01);
        check("t1_preg", cdb_preg, 12'h005);
        check("t1_rob", cdb_rob_idx, 10'h001);
        check("t1_result", cdb_result, 64'hDEAD);
        check("t1_gnt", cdb_gnt, 16'h0008);
        tick();
        check("t1_done", cdb_valid, 0);
        // four FUs contend for two lanes from rr_ptr 0
        do_reset();
        push(0, 6'd10, 5'd0, 32'd0, 4'b0000);
        push(1, 6'd11, 5'd1, 32'd1, 4'b0000);
        push(2, 6'd12, 5'd2, 32'd2, 4'b0000);
        push(5, 6'd15, 5'd5, 32'd5, 4'b0000);
        tick();
        idle();
        tick();
        check("t2_valid_a", cdb_valid, 2'b11);
        check("t2_gnt_a", cdb_gnt, 16'h0201);
        check("t2_preg_a", cdb_preg, 12'h2CA);
        tick();
        check("t2_gnt_b", cdb_gnt, 16'h2004);
        check("t2_preg_b", cdb_preg, 12'h3CC);
        push(0, 6'd1, 5'd0, 32'd0, 4'b0000);
        push(7, 6'd2, 5'd7, 32'd7, 4'b0000);
        tick();
        idle();
        check("t2_gap", cdb_valid, 0);
        tick();
        check("t2_rr6_gnt", cdb_gnt, 16'h0180);
        check("t2_rr6_preg", cdb_preg, 12'h042);
        // FU 4 fills while lower-numbered FUs hold both lanes
        do_reset();
        push(0, 6'd1, 5'd0, 32'd0, 4'b0000);
        push(1, 6'd2, 5'd1, 32'd1, 4'b0000);
        push(4, 6'd21, 5'd4, 32'd4, 4'b0000);
        tick();
        idle();
        push(4, 6'd22, 5'd4, 32'd4, 4'b0000);
        check("t3_ready_1", fu_ready, 8'hFF);
        tick();
        idle();
        check("t3_full", fu_ready, 8'hEF);
        check("t3_gnt_a", cdb_gnt, 16'h0201);
        tick();
        check("t3_ready_back", fu_ready, 8'hFF);
        check("t3_gnt_b", cdb_gnt, 16'h0010);
        check("t3_preg_b", cdb_preg, 12'h015);
        tick();
        check("t3_gnt_c", cdb_gnt, 16'h0010);
        check("t3_preg_c", cdb_preg, 12'h016);
        // mispredict squashes FU 2 head and a same-cycle FU 3 push
        do_reset();
        push(2, 6'd7, 5'd3, 32'h77, 4'b0010);
        push(6, 6'd8, 5'd4, 32'h88, 4'b0001);
        tick();
        idle();
        br_valid = 1'b1;
        br_mispredict = 1'b1;
        br_tag = 4'b0010;
        push(3, 6'd9, 5'd5, 32'h99, 4'b0110);
        tick();
        idle();
        check("t4_valid", cdb_valid, 2'b01);
        check("t4_gnt", cdb_gnt, 16'h0040);
        check("t4_preg", cdb_preg, 12'h008);
        check("t4_ready", fu_ready, 8'hFF);
        tick();
        check("t4_none_a", cdb_valid, 0);
        tick();
        check("t4_none_b", cdb_valid, 0);
        // correct resolve clears the bit, later mispredict on it spares the entries
        do_reset();
        push(0, 6'd1, 5'd0, 32'd0, 4'b0000);
        push(1, 6'd2, 5'd1, 32'd1, 4'b0000);
        push(2, 6'd9, 5'd2, 32'h2222, 4'b0010);
        tick();
        idle();
        br_valid = 1'b1;
        br_tag = 4'b0010;
        push(3, 6'd12, 5'd3, 32'h3333, 4'b0010);
        tick();
        idle();
        br_valid = 1'b1;
        br_mispredict = 1'b1;
        br_tag = 4'b0010;
        check("t5_gnt_a", cdb_gnt, 16'h0201);
        tick();
        idle();
        check("t5_valid_b", cdb_valid, 2'b11);
        check("t5_gnt_b", cdb_gnt, 16'h0804);
        check("t5_preg_b", cdb_preg, 12'h309);
        check("t5_result_b", cdb_result, 64'h0000_3333_0000_2222);
        // asynchronous reset with work in flight
        do_reset();
        for (int i = 0; i < 5; i++) push(i, 6'(i + 1), 5'(i), 32'(i), 4'b0000);
        tick();
        idle();
        tick();
        check("t6_busy", cdb_valid, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", cdb_valid, 0);
        check("t6_async_gnt", cdb_gnt, 0);
        check("t6_async_preg", cdb_preg, 0);
        tick();
        reset = 1'b0;
        check("t6_ready", fu_ready, 8'hFF);
        tick();
        check("t6_stale_a", cdb_valid, 0);
        tick();
        check("t6_stale_b", cdb_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
